digit_encoder_tx: RTL

DIGIT_ENCODER_TX -- requirements
Module: digit_encoder_tx

---
 rtl/codec_pkg.sv | 59 +++++
 rtl/baud_tick_gen.sv | 35 +++
 rtl/digit_encoder_tx.sv | 138 +++++++++++++
 3 files changed

// File: rtl/codec_pkg.sv
// Shared digit codec definitions: frame geometry, FSM encodings and the
// digit <-> code tables used by both the transmitter and the decoder.
package codec_pkg;

    localparam int unsigned FRAME_BITS = 5;
    localparam int unsigned CODE_BITS  = 4;
    localparam logic [3:0]  MAX_DIGIT  = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_GAP   = 2'd3
    } codec_state_e;

    typedef logic [CODE_BITS-1:0] code_t;

    function automatic logic digit_ok(input logic [3:0] d);
        return d <= MAX_DIGIT;
    endfunction

    function automatic code_t encode_digit(input logic [3:0] d);
        code_t c;
        case (d)
            4'd0:    c = 4'b0000;
            4'd1:    c = 4'b0001;
            4'd2:    c = 4'b0011;
            4'd3:    c = 4'b0010;
            4'd4:    c = 4'b0110;
            4'd5:    c = 4'b0111;
            4'd6:    c = 4'b0101;
            4'd7:    c = 4'b0100;
            4'd8:    c = 4'b1000;
            4'd9:    c = 4'b1001;
            default: c = 4'b0000;
        endcase
        return c;
    endfunction

    // Inverse table; unused codes map to 4'hF so a decoder can flag them.
    function automatic logic [3:0] decode_code(input code_t c);
        logic [3:0] d;
        case (c)
            4'b0000: d = 4'd0;
            4'b0001: d = 4'd1;
            4'b0011: d = 4'd2;
            4'b0010: d = 4'd3;
            4'b0110: d = 4'd4;
            4'b0111: d = 4'd5;
            4'b0101: d = 4'd6;
            4'b0100: d = 4'd7;
            4'b1000: d = 4'd8;
            4'b1001: d = 4'd9;
            default: d = 4'hF;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: tick marks the last clk cycle of each bit period;
// restart realigns the period so the next cycle is its first.
module baud_tick_gen #(
    parameter int unsigned BAUD_DIV = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/digit_encoder_tx.sv
// BCD digit serialiser: start bit, 4-bit code MSB first, then an
// idle-low gap; rejects digits above 9 with a one-cycle err pulse.
module digit_encoder_tx
    import codec_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 500000,
    parameter int unsigned GAP_BITS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       signal,
    output logic       busy,
    output logic       err
);

    localparam int unsigned BIT_MAX =
        (GAP_BITS > CODE_BITS) ? GAP_BITS : CODE_BITS;
    localparam int unsigned BW = $clog2(BIT_MAX);
    localparam logic [BW-1:0] LAST_DATA = BW'(CODE_BITS - 1);
    localparam logic [BW-1:0] LAST_GAP  = BW'(GAP_BITS - 1);

    codec_state_e  state_q, state_d;
    logic [BW-1:0] bit_q, bit_d;
    code_t         code_q, code_d;
    logic          signal_q, signal_d;
    logic          busy_q, busy_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d;
    logic          tick;
    logic          restart;
    logic          accept;
    logic [1:0]    idx;

    baud_tick_gen #(
        .BAUD_DIV(BAUD_DIV)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .restart(restart),
        .tick   (tick)
    );

    assign accept = din_valid && ready_q;

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        code_d  = code_q;
        err_d   = 1'b0;
        restart = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    restart = 1'b1;
                    bit_d   = '0;
                    if (digit_ok(din)) begin
                        state_d = ST_START;
                        code_d  = encode_digit(din);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_q == LAST_DATA) begin
                        state_d = ST_GAP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            ST_GAP: begin
                if (tick) begin
                    if (bit_q == LAST_GAP) begin
                        state_d = ST_IDLE;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                bit_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from next state so each lands registered.
    always_comb begin
        idx      = 2'(CODE_BITS - 1) - bit_d[1:0];
        signal_d = 1'b0;
        if (state_d == ST_START) begin
            signal_d = 1'b1;
        end else if (state_d == ST_DATA) begin
            signal_d = code_d[idx];
        end
        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            bit_q    <= '0;
            code_q   <= '0;
            signal_q <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bit_q    <= bit_d;
            code_q   <= code_d;
            signal_q <= signal_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
        end
    end

    assign din_ready = ready_q;
    assign signal    = signal_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule
